// File: rtl/sm83_bus_arbiter.sv
// SM83 machine-cycle phase generator and per-M-cycle arbiter between the CPU core
// and the OAM DMA engine for the shared external bus; the CPU keeps the high page.
module sm83_bus_arbiter #(
  parameter int unsigned          ADR_WIDTH = 16,
  parameter int unsigned          WORD_SIZE = 8,
  parameter logic [ADR_WIDTH-1:0] HIGH_BASE = ADR_WIDTH'(16'hFF80),
  parameter logic [WORD_SIZE-1:0] OPEN_BUS  = WORD_SIZE'(8'hFF)
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 o_t1,
  output logic                 o_t2,
  output logic                 o_t3,
  output logic                 o_t4,
  input  logic                 i_cpu_mread,
  input  logic                 i_cpu_mwrite,
  input  logic [ADR_WIDTH-1:0] i_cpu_addr,
  input  logic [WORD_SIZE-1:0] i_cpu_wdata,
  output logic [WORD_SIZE-1:0] o_cpu_rdata,
  output logic                 o_cpu_rvalid,
  output logic                 o_cpu_blocked,
  input  logic                 i_dma_req,
  input  logic [ADR_WIDTH-1:0] i_dma_addr,
  output logic [WORD_SIZE-1:0] o_dma_rdata,
  output logic                 o_dma_rvalid,
  output logic                 o_bus_mread,
  output logic                 o_bus_mwrite,
  output logic [ADR_WIDTH-1:0] o_bus_aout,
  output logic [WORD_SIZE-1:0] o_bus_dout,
  input  logic [WORD_SIZE-1:0] i_bus_din,
  output logic                 o_int_rd,
  output logic                 o_int_wr,
  output logic [ADR_WIDTH-1:0] o_int_addr,
  output logic [WORD_SIZE-1:0] o_int_dout,
  input  logic [WORD_SIZE-1:0] i_int_din
);

  localparam logic [ADR_WIDTH-1:0] LOW_BYTE_MASK = ADR_WIDTH'(8'hFF);

  typedef enum logic [1:0] {
    PH_T1 = 2'd0,
    PH_T2 = 2'd1,
    PH_T3 = 2'd2,
    PH_T4 = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    OWN_IDLE       = 3'd0,
    OWN_CPU_EXT_RD = 3'd1,
    OWN_CPU_EXT_WR = 3'd2,
    OWN_CPU_INT_RD = 3'd3,
    OWN_CPU_INT_WR = 3'd4,
    OWN_DMA_RD     = 3'd5
  } owner_t;

  phase_t r_phase;
  owner_t r_owner;
  owner_t w_owner_nxt;
  logic   r_dma_rd;
  logic   w_dma_rd_nxt;
  logic   r_blocked;
  logic   w_blocked_nxt;
  logic   r_blk_rd;
  logic   w_blk_rd_nxt;

  logic [ADR_WIDTH-1:0] r_bus_aout;
  logic [ADR_WIDTH-1:0] w_bus_aout_nxt;
  logic [WORD_SIZE-1:0] r_bus_dout;
  logic [WORD_SIZE-1:0] w_bus_dout_nxt;
  logic [ADR_WIDTH-1:0] r_int_addr;
  logic [ADR_WIDTH-1:0] w_int_addr_nxt;
  logic [WORD_SIZE-1:0] r_int_dout;
  logic [WORD_SIZE-1:0] w_int_dout_nxt;
  logic [WORD_SIZE-1:0] r_cpu_rdata;
  logic [WORD_SIZE-1:0] w_cpu_rdata;
  logic [WORD_SIZE-1:0] r_dma_rdata;
  logic [WORD_SIZE-1:0] w_dma_rdata;

  logic w_act;
  logic w_cpu_wr;
  logic w_cpu_rd;
  logic w_cpu_req;
  logic w_cpu_hi;
  logic w_cpu_rvalid;
  logic w_dma_rvalid;
  logic w_bus_mread;
  logic w_bus_mwrite;
  logic w_int_rd;
  logic w_int_wr;

  // Phase counter: parks on T4 in reset so the first free-running cycle is T1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= PH_T4;
    end else begin
      r_phase <= phase_t'(r_phase + 2'd1);
    end
  end

  assign o_t1 = !reset && (r_phase == PH_T1);
  assign o_t2 = !reset && (r_phase == PH_T2);
  assign o_t3 = !reset && (r_phase == PH_T3);
  assign o_t4 = reset || (r_phase == PH_T4);

  // Decision/return slot; requests are ignored while reset is held.
  assign w_act     = !reset && (r_phase == PH_T4);
  assign w_cpu_wr  = i_cpu_mwrite;
  assign w_cpu_rd  = i_cpu_mread && !i_cpu_mwrite;
  assign w_cpu_req = w_cpu_wr || w_cpu_rd;
  assign w_cpu_hi  = (i_cpu_addr >= HIGH_BASE);

  // Owner/flag state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= OWN_IDLE;
      r_dma_rd  <= 1'b0;
      r_blocked <= 1'b0;
      r_blk_rd  <= 1'b0;
    end else begin
      r_owner   <= w_owner_nxt;
      r_dma_rd  <= w_dma_rd_nxt;
      r_blocked <= w_blocked_nxt;
      r_blk_rd  <= w_blk_rd_nxt;
    end
  end

  // Port address/data latches and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_aout  <= '0;
      r_bus_dout  <= '0;
      r_int_addr  <= '0;
      r_int_dout  <= '0;
      r_cpu_rdata <= OPEN_BUS;
      r_dma_rdata <= '0;
    end else begin
      r_bus_aout  <= w_bus_aout_nxt;
      r_bus_dout  <= w_bus_dout_nxt;
      r_int_addr  <= w_int_addr_nxt;
      r_int_dout  <= w_int_dout_nxt;
      r_cpu_rdata <= w_cpu_rdata;
      r_dma_rdata <= w_dma_rdata;
    end
  end

  // At T4: return for the finishing M-cycle (old owner) and grant for the next one.
  always_comb begin
    w_owner_nxt    = r_owner;
    w_dma_rd_nxt   = r_dma_rd;
    w_blocked_nxt  = r_blocked;
    w_blk_rd_nxt   = r_blk_rd;
    w_bus_aout_nxt = r_bus_aout;
    w_bus_dout_nxt = r_bus_dout;
    w_int_addr_nxt = r_int_addr;
    w_int_dout_nxt = r_int_dout;
    w_cpu_rvalid   = 1'b0;
    w_cpu_rdata    = r_cpu_rdata;
    w_dma_rvalid   = 1'b0;
    w_dma_rdata    = r_dma_rdata;
    w_bus_mread    = 1'b0;
    w_bus_mwrite   = 1'b0;
    w_int_rd       = 1'b0;
    w_int_wr       = 1'b0;

    if (w_act) begin
      case (r_owner)
        OWN_CPU_EXT_RD: begin
          w_cpu_rvalid = 1'b1;
          w_cpu_rdata  = i_bus_din;
        end
        OWN_CPU_INT_RD: begin
          w_cpu_rvalid = 1'b1;
          w_cpu_rdata  = i_int_din;
        end
        default: ;
      endcase
      if (r_blk_rd) begin
        w_cpu_rvalid = 1'b1;
        w_cpu_rdata  = OPEN_BUS;
      end
      if (r_dma_rd) begin
        w_dma_rvalid = 1'b1;
        w_dma_rdata  = i_bus_din;
      end

      w_owner_nxt   = OWN_IDLE;
      w_dma_rd_nxt  = 1'b0;
      w_blocked_nxt = 1'b0;
      w_blk_rd_nxt  = 1'b0;

      if (w_cpu_req && w_cpu_hi) begin
        w_int_rd       = w_cpu_rd;
        w_int_wr       = w_cpu_wr;
        w_int_addr_nxt = i_cpu_addr;
        w_owner_nxt    = w_cpu_wr ? OWN_CPU_INT_WR : OWN_CPU_INT_RD;
        if (w_cpu_wr) begin
          w_int_dout_nxt = i_cpu_wdata;
        end
      end

      if (i_dma_req) begin
        w_bus_mread    = 1'b1;
        w_bus_aout_nxt = i_dma_addr;
        w_dma_rd_nxt   = 1'b1;
        if (!(w_cpu_req && w_cpu_hi)) begin
          w_owner_nxt = OWN_DMA_RD;
        end
        if (w_cpu_req && !w_cpu_hi) begin
          w_blocked_nxt = 1'b1;
          w_blk_rd_nxt  = w_cpu_rd;
        end
      end else if (w_cpu_req && !w_cpu_hi) begin
        w_bus_mread    = w_cpu_rd;
        w_bus_mwrite   = w_cpu_wr;
        w_bus_aout_nxt = i_cpu_addr;
        w_owner_nxt    = w_cpu_wr ? OWN_CPU_EXT_WR : OWN_CPU_EXT_RD;
        if (w_cpu_wr) begin
          w_bus_dout_nxt = i_cpu_wdata;
        end
      end else begin
        w_bus_aout_nxt = r_bus_aout & LOW_BYTE_MASK;
      end
    end
  end

  assign o_cpu_rdata   = w_cpu_rdata;
  assign o_cpu_rvalid  = w_cpu_rvalid;
  assign o_cpu_blocked = r_blocked;
  assign o_dma_rdata   = w_dma_rdata;
  assign o_dma_rvalid  = w_dma_rvalid;
  assign o_bus_mread   = w_bus_mread;
  assign o_bus_mwrite  = w_bus_mwrite;
  assign o_bus_aout    = r_bus_aout;
  assign o_bus_dout    = r_bus_dout;
  assign o_int_rd      = w_int_rd;
  assign o_int_wr      = w_int_wr;
  assign o_int_addr    = r_int_addr;
  assign o_int_dout    = r_int_dout;

endmodule

// File: tb/tb_sm83_bus_arbiter.sv
// Scoreboard bench for sm83_bus_arbiter: directed M-cycles push expected returns,
// a forked monitor pops them whenever the DUT raises cpu_rvalid / dma_rvalid.
module tb_sm83_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        t1, t2, t3, t4;
  logic        cpu_mread = 1'b0;
  logic        cpu_mwrite = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_blocked;
  logic        dma_req = 1'b0;
  logic [15:0] dma_addr = 16'h0000;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic        bus_mread, bus_mwrite;
  logic [15:0] bus_aout;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din = 8'h00;
  logic        int_rd, int_wr;
  logic [15:0] int_addr;
  logic [7:0]  int_dout;
  logic [7:0]  int_din = 8'h00;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] q_cpu[$];
  logic [7:0] q_dma[$];

  always #5 clk = ~clk;

  sm83_bus_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .o_t1         (t1),
    .o_t2         (t2),
    .o_t3         (t3),
    .o_t4         (t4),
    .i_cpu_mread  (cpu_mread),
    .i_cpu_mwrite (cpu_mwrite),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_rdata  (cpu_rdata),
    .o_cpu_rvalid (cpu_rvalid),
    .o_cpu_blocked(cpu_blocked),
    .i_dma_req    (dma_req),
    .i_dma_addr   (dma_addr),
    .o_dma_rdata  (dma_rdata),
    .o_dma_rvalid (dma_rvalid),
    .o_bus_mread  (bus_mread),
    .o_bus_mwrite (bus_mwrite),
    .o_bus_aout   (bus_aout),
    .o_bus_dout   (bus_dout),
    .i_bus_din    (bus_din),
    .o_int_rd     (int_rd),
    .o_int_wr     (int_wr),
    .o_int_addr   (int_addr),
    .o_int_dout   (int_dout),
    .i_int_din    (int_din)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Lands #1 after the edge that starts T4.
  task automatic goto_t4();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!seen) begin
        @(negedge clk);
        seen = t3;
      end
    end
    chk("wait_t3", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One M-cycle: drive requests and return data during T4, check strobes {bus_mread,bus_mwrite,int_rd,int_wr}.
  task automatic mcycle(input string name, input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [7:0] wd, input logic dma, input logic [15:0] daddr,
                        input logic [7:0] bdin, input logic [7:0] idin, input logic [3:0] exp_strb);
    goto_t4();
    cpu_mread  = rd;
    cpu_mwrite = wr;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    dma_req    = dma;
    dma_addr   = daddr;
    bus_din    = bdin;
    int_din    = idin;
    #1;
    chk({name, "_strobes"}, 32'({bus_mread, bus_mwrite, int_rd, int_wr}), 32'(exp_strb));
    @(posedge clk);
    #1;
    cpu_mread  = 1'b0;
    cpu_mwrite = 1'b0;
    dma_req    = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (cpu_rvalid) begin
          if (q_cpu.size() == 0) chk("cpu_rvalid_unexpected", 32'd1, 32'd0);
          else chk("cpu_rdata", 32'(cpu_rdata), 32'(q_cpu.pop_front()));
        end
        if (dma_rvalid) begin
          if (q_dma.size() == 0) chk("dma_rvalid_unexpected", 32'd1, 32'd0);
          else chk("dma_rdata", 32'(dma_rdata), 32'(q_dma.pop_front()));
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_phase", 32'({t1, t2, t3, t4}), 32'h1);
    chk("rst_strobes", 32'({bus_mread, bus_mwrite, int_rd, int_wr, cpu_rvalid, dma_rvalid, cpu_blocked}), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_dma_rdata", 32'(dma_rdata), 32'h00);
    chk("rst_addr", 32'({bus_aout, int_addr}), 32'd0);
    chk("rst_dout", 32'({bus_dout, int_dout}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("release_t4", 32'({t1, t2, t3, t4}), 32'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("phase_seq", 32'({t1, t2, t3, t4}), 32'(4'b1000 >> (i % 4)));
      chk("idle_strobes", 32'({bus_mread, bus_mwrite, int_rd, int_wr}), 32'd0);
    end
    chk("idle_cpu_rdata", 32'(cpu_rdata), 32'hFF);

    // CPU external read
    q_cpu.push_back(8'h5A);
    mcycle("cpu_rd", 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00, 4'b1000);
    chk("cpu_rd_aout", 32'(bus_aout), 32'h1234);
    chk("cpu_rd_blocked", 32'(cpu_blocked), 32'd0);

    // DMA beats a CPU external read; CPU read returns open bus
    q_dma.push_back(8'hA7);
    q_cpu.push_back(8'hFF);
    mcycle("dma_vs_rd", 1'b1, 1'b0, 16'h2000, 8'h00, 1'b1, 16'hC000, 8'h5A, 8'h00, 4'b1000);
    chk("dma_vs_rd_aout", 32'(bus_aout), 32'hC000);
    chk("dma_vs_rd_blocked", 32'(cpu_blocked), 32'd1);
    chk("rdata_hold", 32'(cpu_rdata), 32'h5A);

    // DMA and CPU high-page write proceed together
    q_dma.push_back(8'h3E);
    mcycle("dma_int_wr", 1'b0, 1'b1, 16'hFF90, 8'h77, 1'b1, 16'hC001, 8'hA7, 8'h00, 4'b1001);
    chk("int_wr_addr", 32'(int_addr), 32'hFF90);
    chk("int_wr_dout", 32'(int_dout), 32'h77);
    chk("int_wr_blocked", 32'(cpu_blocked), 32'd0);
    chk("int_wr_aout", 32'(bus_aout), 32'hC001);
    chk("blk_rdata_hold", 32'(cpu_rdata), 32'hFF);
    chk("dma_rdata_hold", 32'(dma_rdata), 32'hA7);

    // CPU external write dropped under DMA
    q_dma.push_back(8'h91);
    mcycle("dma_vs_wr", 1'b0, 1'b1, 16'h8000, 8'h3C, 1'b1, 16'hC000, 8'h3E, 8'h00, 4'b1000);
    chk("dma_vs_wr_blocked", 32'(cpu_blocked), 32'd1);
    chk("dma_vs_wr_dout", 32'(bus_dout), 32'h00);

    // Idle: upper address byte cleared, low byte held
    mcycle("idle", 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h91, 8'h00, 4'b0000);
    chk("idle_aout", 32'(bus_aout), 32'h0000);
    chk("idle_blocked", 32'(cpu_blocked), 32'd0);

    // HIGH_BASE boundary: 0xFF80 internal, 0xFF7F external
    q_cpu.push_back(8'h42);
    mcycle("hi_rd", 1'b1, 1'b0, 16'hFF80, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h00, 4'b0010);
    chk("hi_rd_addr", 32'(int_addr), 32'hFF80);
    q_cpu.push_back(8'h13);
    mcycle("lo_rd", 1'b1, 1'b0, 16'hFF7F, 8'h00, 1'b0, 16'h0000, 8'h00, 8'h42, 4'b1000);
    chk("lo_rd_aout", 32'(bus_aout), 32'hFF7F);
    mcycle("ext_wr", 1'b0, 1'b1, 16'h4000, 8'hC5, 1'b0, 16'h0000, 8'h13, 8'h00, 4'b0100);
    chk("ext_wr_aout", 32'(bus_aout), 32'h4000);
    chk("ext_wr_dout", 32'(bus_dout), 32'hC5);

    // DMA read interrupted by reset during T2: its return is dropped
    mcycle("dma_rst", 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 16'hC002, 8'h00, 8'h00, 4'b1000);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    bus_din = 8'h66;
    @(negedge clk);
    chk("midrst_t4", 32'(t4), 32'd1);
    chk("midrst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rel_dma_rvalid", 32'(dma_rvalid), 32'd0);
    @(negedge clk);
    chk("midrst_t1", 32'({t1, t2, t3, t4}), 32'h8);
    chk("midrst_aout", 32'(bus_aout), 32'h0000);

    // Normal read after reset
    q_cpu.push_back(8'h24);
    mcycle("post_rd", 1'b1, 1'b0, 16'h0100, 8'h00, 1'b0, 16'h0000, 8'h66, 8'h00, 4'b1000);
    chk("post_rd_aout", 32'(bus_aout), 32'h0100);
    mcycle("post_ret", 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 8'h24, 8'h00, 4'b0000);
    repeat (4) @(negedge clk);

    chk("cpu_q_drained", 32'(q_cpu.size()), 32'd0);
    chk("dma_q_drained", 32'(q_dma.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm83_bus_arbiter.md
Name: sm83_bus_arbiter

Overview:
- Generates the T1..T4 machine-cycle phases.
- Shares the single external memory bus between the CPU core and the OAM DMA engine on a per-M-cycle basis. DMA wins the bus; the CPU keeps the internal high-page port (HRAM/IE) at all times.
- Sits between the CPU core / DMA unit and the external bus interface.
- Produces the mread/mwrite strobes and address that the bus interface expects at T4.

Parameters:
ADR_WIDTH, 16, address width
WORD_SIZE, 8, data width
HIGH_BASE, 16'hFF80, lowest address routed to the internal port
OPEN_BUS, 8'hFF, read value returned to a blocked CPU read

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
t1,t2,t3,t4  out  1 each  one-hot phase strobes
cpu_mread  in  1  CPU read request, valid only while t4
cpu_mwrite  in  1  CPU write request, valid only while t4
cpu_addr  in  ADR_WIDTH  CPU address, sampled at t4
cpu_wdata  in  WORD_SIZE  CPU write data, sampled at t4
cpu_rdata  out  WORD_SIZE  read data to CPU
cpu_rvalid  out  1  cpu_rdata valid, pulse
cpu_blocked  out  1  current M-cycle's CPU external access was denied
dma_req  in  1  DMA read request, valid only while t4
dma_addr  in  ADR_WIDTH  DMA source address
dma_rdata  out  WORD_SIZE  read data to DMA
dma_rvalid  out  1  dma_rdata valid, pulse
bus_mread, bus_mwrite  out  1 each  external bus strobes, only while t4
bus_aout  out  ADR_WIDTH  external address
bus_dout  out  WORD_SIZE  external write data
bus_din  in  WORD_SIZE  external read data, valid at t4 of the access cycle
int_rd, int_wr  out  1 each  internal port strobes, only while t4
int_addr  out  ADR_WIDTH  internal port address
int_dout  out  WORD_SIZE  internal port write data
int_din  in  WORD_SIZE  internal port read data, valid at t4 of the access cycle

Behaviour:
- Phase counter, 2 bits:
  - Advances T1→T2→T3→T4→T1 every clk.
  - Reset loads T4, and t4=1 while reset is asserted. The first cycle after reset deasserts is T1.
  - All request inputs are ignored during reset.
- Reset values:
  - All strobes, cpu_rvalid, dma_rvalid and cpu_blocked = 0.
  - bus_aout, int_addr, bus_dout and int_dout = 0.
  - cpu_rdata = OPEN_BUS; dma_rdata = 0.
  - Owner state = IDLE.
- Decision happens at t4 (combinational, same cycle as the request):
  - CPU request with cpu_addr >= HIGH_BASE:
    - Goes to the internal port: int_rd/int_wr = cpu_mread/cpu_mwrite.
    - Never blocked, and independent of DMA.
  - Otherwise, if dma_req: DMA wins.
    - bus_mread = 1 and bus_aout is set from dma_addr.
    - A concurrent CPU external request is denied.
  - Otherwise, a CPU external request goes to the bus: bus_mread/bus_mwrite = cpu_mread/cpu_mwrite.
  - No request: strobes stay 0 and the owner becomes IDLE.
- Registered at the t4 clk edge; values are held for the whole following M-cycle:
  - Owner state: IDLE / CPU_EXT_RD / CPU_EXT_WR / CPU_INT_RD / CPU_INT_WR / DMA_RD.
  - Blocked flag: denied read or write.
  - bus_aout / int_addr and bus_dout / int_dout. Only the granted port's registers update.
  - When the bus is not granted, bus_aout[ADR_WIDTH-1:8] is cleared to 0 and the low byte is held.
- Read return, at t4 of the next M-cycle (latency one M-cycle = 4 clks):
  - CPU_*_RD: cpu_rdata = bus_din or int_din, cpu_rvalid = 1.
  - DMA_RD: dma_rdata = bus_din, dma_rvalid = 1.
  - Blocked CPU read: cpu_rdata = OPEN_BUS, cpu_rvalid = 1.
  - cpu_rdata/dma_rdata hold their last value outside t4.
- Writes and blocking:
  - A blocked CPU write is silently dropped; no strobe is issued.
  - cpu_blocked is high for the whole M-cycle after the denial.
- Simultaneous events:
  - At t4, the return of cycle n and the grant for cycle n+1 both occur. Return outputs use the old owner state.
  - cpu_mread && cpu_mwrite together is illegal. The bench treats it as a protocol violation, and the design gives write precedence.
- DMA and CPU on separate ports (internal CPU access + DMA) both proceed in the same M-cycle.
- Reset mid-cycle:
  - Owner goes to IDLE and any pending return is dropped (no rvalid).
  - The phase restarts per the phase-counter rule.

Test Plan:
- Release reset, no requests → t1,t2,t3,t4 repeat with period 4; all strobes 0; cpu_rdata=FF.
- CPU read 0x1234 at t4, bus_din=0x5A at next t4 → bus_mread pulse, bus_aout=0x1234; cpu_rdata=0x5A with cpu_rvalid exactly at t4, 4 clks later.
- DMA read 0xC000 plus CPU read 0x2000 at the same t4 → bus_aout=0xC000, dma_rdata=bus_din; cpu_blocked=1, cpu_rdata=FF.
- DMA read 0xC001 plus CPU write 0xFF90←0x77 → both served; int_wr pulse, int_addr=0xFF90, int_dout=0x77; no cpu_blocked.
- CPU write 0x8000←0x3C with dma_req → no bus_mwrite; next idle cycle bus_aout=0x0000 (upper byte cleared, low byte held at 0x00).
- Reset asserted during T2 of a DMA read → no dma_rvalid; after release the phase restarts at T1 and the owner is IDLE.
